// File: rtl/mouse_click_decoder_if.sv
// Click-event handshake between the decoder (master) and the game FSM (slave).
interface mouse_click_decoder_if;
  logic       click_valid;
  logic       click_ready;
  logic [3:0] click_col;
  logic [3:0] click_row;
  logic [1:0] click_action;

  modport master (output click_valid, click_col, click_row, click_action, input click_ready);
  modport slave  (input click_valid, click_col, click_row, click_action, output click_ready);
endinterface

// File: rtl/mouse_click_decoder.sv
// Turns mouse button presses into board-cell click events via iterative division.
// Optional MOUSE_CHORD_EN: a press with the other button held (or both together) yields action 11.
module mouse_click_decoder (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          left,
  input  logic                          right,
  input  logic [11:0]                   mouse_xpos,
  input  logic [11:0]                   mouse_ypos,
  input  logic [11:0]                   board_xpos,
  input  logic [11:0]                   board_ypos,
  input  logic [5:0]                    cell_size,
  input  logic [4:0]                    board_cols,
  input  logic [4:0]                    board_rows,
  output logic                          busy,
  mouse_click_decoder_if.master         click
);

  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, VALID} state_t;

  state_t      state;
  logic        left_q, right_q;
  logic [11:0] rem_x, rem_y;
  logic [3:0]  col_cnt, row_cnt;
  logic [1:0]  act;

  logic        lrise, rrise, off_board;
  logic [1:0]  edge_act;
  logic [11:0] cs_ext;

  always_comb begin
    lrise     = left & ~left_q;
    rrise     = right & ~right_q;
    cs_ext    = {6'd0, cell_size};
    off_board = (mouse_xpos < board_xpos) | (mouse_ypos < board_ypos) |
                (cell_size == 6'd0) | (board_cols == 5'd0) | (board_rows == 5'd0);
`ifdef MOUSE_CHORD_EN
    if ((lrise & right) | (rrise & left)) edge_act = 2'b11;
    else if (lrise)                       edge_act = 2'b01;
    else                                  edge_act = 2'b10;
`else
    edge_act = lrise ? 2'b01 : 2'b10;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      left_q             <= 1'b1;
      right_q            <= 1'b1;
      rem_x              <= '0;
      rem_y              <= '0;
      col_cnt            <= '0;
      row_cnt            <= '0;
      act                <= '0;
      busy               <= 1'b0;
      click.click_valid  <= 1'b0;
      click.click_col    <= '0;
      click.click_row    <= '0;
      click.click_action <= '0;
    end else begin
      // History tracks every cycle so presses made while busy never surface later.
      left_q  <= left;
      right_q <= right;
      case (state)
        IDLE: begin
          if ((lrise | rrise) && !off_board) begin
            act     <= edge_act;
            rem_x   <= mouse_xpos - board_xpos;
            rem_y   <= mouse_ypos - board_ypos;
            col_cnt <= '0;
            row_cnt <= '0;
            busy    <= 1'b1;
            state   <= DIV_X;
          end
        end
        DIV_X: begin
          if (rem_x < cs_ext) state <= DIV_Y;
          else if ({1'b0, col_cnt} == board_cols - 5'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem_x   <= rem_x - cs_ext;
            col_cnt <= col_cnt + 4'd1;
          end
        end
        DIV_Y: begin
          if (rem_y < cs_ext) begin
            click.click_valid  <= 1'b1;
            click.click_col    <= col_cnt;
            click.click_row    <= row_cnt;
            click.click_action <= act;
            state              <= VALID;
          end else if ({1'b0, row_cnt} == board_rows - 5'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem_y   <= rem_y - cs_ext;
            row_cnt <= row_cnt + 4'd1;
          end
        end
        VALID: begin
          if (click.click_ready) begin
            click.click_valid <= 1'b0;
            busy              <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_click_decoder.sv
// Directed bench for mouse_click_decoder on a 8x8 board of 32-pixel cells at (100,50).
module tb_mouse_click_decoder;
  logic        clk, rst, left, right, busy;
  logic [11:0] mouse_xpos, mouse_ypos, board_xpos, board_ypos;
  logic [5:0]  cell_size;
  logic [4:0]  board_cols, board_rows;
  int          n_tests, n_fail;

  mouse_click_decoder_if evt ();

  mouse_click_decoder dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .board_xpos(board_xpos), .board_ypos(board_ypos),
    .cell_size(cell_size), .board_cols(board_cols), .board_rows(board_rows),
    .busy(busy), .click(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // Apply buttons/position, return cycles from the sampling edge until click_valid (-1 on timeout).
  task automatic press(input logic l, input logic r, input int x, input int y, output int lat);
    left = l; right = r; mouse_xpos = x[11:0]; mouse_ypos = y[11:0];
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (evt.click_valid) begin lat = k - 1; break; end
    end
  endtask

  task automatic release_all();
    left = 1'b0; right = 1'b0;
    tick(2);
  endtask

  initial begin
    int lat, k, seen_busy, seen_vld, bad, hs;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; left = 1'b0; right = 1'b0; evt.click_ready = 1'b0;
    mouse_xpos = '0; mouse_ypos = '0;
    board_xpos = 12'd100; board_ypos = 12'd50; cell_size = 6'd32;
    board_cols = 5'd8; board_rows = 5'd8;
    tick(3);
    chk("rst_valid", {31'd0, evt.click_valid}, 0);
    chk("rst_col", {28'd0, evt.click_col}, 0);
    chk("rst_row", {28'd0, evt.click_row}, 0);
    chk("rst_action", {30'd0, evt.click_action}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    tick(2);

    // Basic reveal, 1-cycle pulse with ready already high
    evt.click_ready = 1'b1;
    press(1'b1, 1'b0, 180, 120, lat);
    chk("t1_lat", lat, 6);
    chk("t1_col", {28'd0, evt.click_col}, 2);
    chk("t1_row", {28'd0, evt.click_row}, 2);
    chk("t1_action", {30'd0, evt.click_action}, 1);
    tick(1);
    chk("t1_pulse", {31'd0, evt.click_valid}, 0);
    release_all();

    // Exact cell-boundary remainder
    press(1'b1, 1'b0, 132, 82, lat);
    chk("edge_lat", lat, 4);
    chk("edge_col", {28'd0, evt.click_col}, 1);
    chk("edge_row", {28'd0, evt.click_row}, 1);
    release_all();

    // Last cell, flag
    press(1'b0, 1'b1, 355, 305, lat);
    chk("t2_lat", lat, 16);
    chk("t2_col", {28'd0, evt.click_col}, 7);
    chk("t2_row", {28'd0, evt.click_row}, 7);
    chk("t2_action", {30'd0, evt.click_action}, 2);
    release_all();

    // One pixel past the right edge: dropped during DIV_X
    left = 1'b1; mouse_xpos = 12'd356; mouse_ypos = 12'd60;
    tick(1);
    chk("t3_busy_rise", {31'd0, busy}, 1);
    k = -1; seen_vld = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (evt.click_valid) seen_vld = 1;
      if (!busy) begin k = i; break; end
    end
    chk("t3_busy_fall", k, 8);
    chk("t3_no_valid", seen_vld, 0);
    chk("t3_keep_col", {28'd0, evt.click_col}, 7);
    chk("t3_keep_action", {30'd0, evt.click_action}, 2);
    release_all();

    // Left of the board: rejected in IDLE
    left = 1'b1; mouse_xpos = 12'd99; mouse_ypos = 12'd60;
    seen_busy = 0; seen_vld = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (busy) seen_busy = 1;
      if (evt.click_valid) seen_vld = 1;
    end
    chk("t4_no_busy", seen_busy, 0);
    chk("t4_no_valid", seen_vld, 0);
    release_all();

    // Backpressure: outputs hold while buttons chatter, then exactly one handshake
    evt.click_ready = 1'b0;
    press(1'b1, 1'b0, 180, 120, lat);
    chk("t5_lat", lat, 6);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      left = ~left; right = (i % 3) == 0;
      tick(1);
      if (!evt.click_valid || evt.click_col != 4'd2 || evt.click_row != 4'd2 ||
          evt.click_action != 2'b01) bad++;
    end
    chk("t5_stable", bad, 0);
    left = 1'b0; right = 1'b0;
    evt.click_ready = 1'b1;
    hs = evt.click_valid ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (evt.click_valid) hs++;
    end
    chk("t5_handshakes", hs, 1);

    // Reset mid-division with left held
    press(1'b1, 1'b0, 355, 305, lat);
    chk("t6_first", lat, 16);
    release_all();
    left = 1'b1; mouse_xpos = 12'd355; mouse_ypos = 12'd305;
    tick(3);
    chk("t6_busy_pre", {31'd0, busy}, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_valid", {31'd0, evt.click_valid}, 0);
    chk("t6_col", {28'd0, evt.click_col}, 0);
    chk("t6_row", {28'd0, evt.click_row}, 0);
    chk("t6_action", {30'd0, evt.click_action}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    seen_busy = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (busy || evt.click_valid) seen_busy = 1;
    end
    chk("t6_held_no_event", seen_busy, 0);
    release_all();
    press(1'b1, 1'b0, 355, 305, lat);
    chk("t6_repress", lat, 16);
    release_all();

    // Simultaneous edges
    press(1'b1, 1'b1, 180, 120, lat);
    chk("t7_both_lat", lat, 6);
`ifdef MOUSE_CHORD_EN
    chk("t7_both_action", {30'd0, evt.click_action}, 3);
`else
    chk("t7_both_action", {30'd0, evt.click_action}, 1);
`endif
    release_all();

    // Left held (its own press dropped off-board), then right pressed on board
    left = 1'b1; mouse_xpos = 12'd99; mouse_ypos = 12'd60;
    tick(2);
    press(1'b1, 1'b1, 180, 120, lat);
    chk("t7_held_lat", lat, 6);
`ifdef MOUSE_CHORD_EN
    chk("t7_held_action", {30'd0, evt.click_action}, 3);
`else
    chk("t7_held_action", {30'd0, evt.click_action}, 2);
`endif
    release_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
